multiword_add_sequencer: RTL and testbench

Multi-precision add controller that time-shares one combinational carry_bypass_adder instance across WORDS chunks of WIDTH bits. It computes a WIDTH*WORDS-bit sum by feeding chunks LSB-first and chaining carry through a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/multiword_add_sequencer.sv | 161 ++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder: one WIDTH-bit carry-bypass adder reused over WORDS chunks, LSB first.
// Latency: accept at edge E0, out_valid high after edge E0+WORDS; one op per WORDS+2 cycles.
// Backpressure: in_ready low while busy; the result is held in DONE until out_ready.

`ifndef INPUT_LEN
`define INPUT_LEN 8
`endif

// Chunk adder: ripple inside 4-bit blocks, block carry skips ahead when every bit propagates.
module carry_bypass_adder (
    input  logic [`INPUT_LEN-1:0] a,
    input  logic [`INPUT_LEN-1:0] b,
    input  logic                  cin,
    output logic [`INPUT_LEN-1:0] sum,
    output logic                  cout
);
    localparam int N   = `INPUT_LEN;
    localparam int BLK = 4;

    logic c_blk;
    logic c_rip;
    logic p_blk;
    logic p;

    // Per block: ripple for the sum bits, then choose the bypassed or the rippled block carry
    always_comb begin
        c_blk = cin;
        c_rip = 1'b0;
        p_blk = 1'b1;
        p     = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            if ((i % BLK) == 0) begin
                c_rip = c_blk;
                p_blk = 1'b1;
            end
            p      = a[i] ^ b[i];
            sum[i] = p ^ c_rip;
            c_rip  = (a[i] & b[i]) | (p & c_rip);
            p_blk  = p_blk & p;
            if (((i % BLK) == (BLK - 1)) || (i == (N - 1))) begin
                c_blk = p_blk ? c_blk : c_rip;
            end
        end
        cout = c_blk;
    end
endmodule

module multiword_add_sequencer #(
    parameter int WIDTH = 8,   // must match `INPUT_LEN, the adder is sized by it
    parameter int WORDS = 4    // >= 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   busy
);
    localparam int TW   = WIDTH * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [TW-1:0]     a_q;
    logic [TW-1:0]     b_q;
    logic [TW-1:0]     sum_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [WIDTH-1:0]  a_chunk;
    logic [WIDTH-1:0]  b_chunk;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

    // Operand chunk selected by the current index, fed to the shared adder
    always_comb begin
        a_chunk = a_q[int'(idx_q) * WIDTH +: WIDTH];
        b_chunk = b_q[int'(idx_q) * WIDTH +: WIDTH];
    end

    carry_bypass_adder u_adder (a_chunk, b_chunk, carry_q, add_sum, add_cout);

    // Sequencer FSM; all handshake outputs are registered so they depend only on state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q) * WIDTH +: WIDTH] <= add_sum;
                    carry_q <= add_cout;
                    if (idx_q == IDX_LAST) begin
                        idx_q       <= '0;
                        cout_q      <= add_cout;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with WIDTH=8, WORDS=4.
// Latency: checks out_valid arrives exactly 4 edges after accept.
// Backpressure: checks result hold in DONE and accept spacing of 6 cycles.

module tb_multiword_add_sequencer;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    multiword_add_sequencer #(.WIDTH(8), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, take the accept edge, scramble inputs, then wait for out_valid
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                          output int lat, output logic bsy, output logic rdy);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; cin = ~tc;
        bsy = busy;
        rdy = in_ready;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // One out_ready edge to release a result
    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({cout, sum} !== 33'h0) begin errors++; $display("FAIL reset_sum got=%b_%h exp=0_00000000", cout, sum); end
        // out_ready in IDLE must not change anything
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_out_ready got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry_wrap();
        int lat; logic bsy, rdy;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, bsy, rdy);
        checks++; if (bsy !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL wrap_busy got busy=%b in_ready=%b exp 1 0", bsy, rdy); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
        checks++; if (sum !== 32'h0000_0000) begin errors++; $display("FAIL wrap_sum got=%h exp=00000000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b exp=1", cout); end
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL wrap_handshake got out_valid=%b in_ready=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_mixed();
        int lat; logic bsy, rdy;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, lat, bsy, rdy);
        checks++; if (lat !== 4) begin errors++; $display("FAIL mixed_latency got=%0d exp=4", lat); end
        checks++; if ({cout, sum} !== {1'b0, 32'h2345_678A}) begin errors++; $display("FAIL mixed_sum got=%b_%h exp=0_2345678a", cout, sum); end
        drain();
    endtask

    task automatic test_full_propagate();
        int lat; logic bsy, rdy;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bsy, rdy);
        checks++; if (lat !== 4) begin errors++; $display("FAIL prop_latency got=%0d exp=4", lat); end
        checks++; if ({cout, sum} !== {1'b1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL prop_sum got=%b_%h exp=1_ffffffff", cout, sum); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat; logic bsy, rdy; int bad;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat, bsy, rdy);
        checks++; if ({cout, sum} !== {1'b0, 32'h0000_0100}) begin errors++; $display("FAIL bp_sum got=%b_%h exp=0_00000100", cout, sum); end
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b1; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({cout, sum} !== {1'b0, 32'h0000_0100} || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got bad_cycles=%0d exp=0 (sum=%h in_ready=%b out_valid=%b)", bad, sum, in_ready, out_valid); end
        in_valid = 1'b0;
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        tick();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_not_taken got busy=%b in_ready=%b exp 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic bsy, rdy;
        a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_state got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
        end
        checks++; if ({cout, sum} !== 33'h0) begin errors++; $display("FAIL abort_sum got=%b_%h exp=0_00000000", cout, sum); end
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, lat, bsy, rdy);
        checks++; if (lat !== 4 || {cout, sum} !== {1'b0, 32'h0000_0007}) begin
            errors++; $display("FAIL abort_next got lat=%0d sum=%b_%h exp lat=4 sum=0_00000007", lat, cout, sum);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q[$];
        logic [32:0] exp;
        int n_acc, n_res, cyc, last_acc;
        logic acc;
        n_acc = 0; n_res = 0; cyc = 0; last_acc = -1;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1; out_ready = 1'b1;
        while (n_res < 20 && cyc < 400) begin
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back({1'b0, a} + {1'b0, b} + {32'b0, cin});
            tick();
            cyc++;
            if (acc) begin
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc !== 6) begin errors++; $display("FAIL b2b_spacing got=%0d exp=6", cyc - last_acc); end
                end
                last_acc = cyc;
                n_acc++;
                a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
                if (n_acc == 20) in_valid = 1'b0;
            end
            if (out_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
                checks++; if ({cout, sum} !== exp) begin errors++; $display("FAIL b2b_sum op=%0d got=%b_%h exp=%b_%h", n_res, cout, sum, exp[32], exp[31:0]); end
                n_res++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (n_res !== 20) begin errors++; $display("FAIL b2b_timeout got results=%0d exp=20", n_res); end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_mixed();
        test_full_propagate();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
